// File: rtl/vector_sweep_gen_if.sv
// Stimulus/response bundle between the sweep sequencer (master) and the
// environment that feeds it requests and the block-under-sweep response (slave).
interface vector_sweep_gen_if;
  logic        start;
  logic        abort;
  logic        s_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  // `table` is a reserved word in SystemVerilog, so the captured word is truth_table.
  logic [15:0] truth_table;

  modport master (
    input  start, abort, s_in,
    output a, b, c, d, vec_idx, busy, done, truth_table
  );

  modport slave (
    output start, abort, s_in,
    input  a, b, c, d, vec_idx, busy, done, truth_table
  );
endinterface

// File: rtl/vector_sweep_gen.sv
// Self-timed sweep of all 16 {a,b,c,d} vectors into a combinational block,
// holding each HOLD cycles and capturing the response as a truth-table word.
module vector_sweep_gen #(
  parameter int unsigned HOLD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  vector_sweep_gen_if.master bus
);
  localparam logic [7:0] HOLD_LAST = (HOLD <= 1) ? 8'd0 : 8'(HOLD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q;
  logic [3:0]  vec_q;
  logic [7:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tbl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_DRIVE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            tbl_q   <= '0;
          end
        end
        ST_DRIVE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == HOLD_LAST) begin
            tbl_q[vec_q] <= bus.s_in;
            cnt_q        <= '0;
            if (vec_q == 4'd15) begin
              state_q <= ST_DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          vec_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // vec_q is forced to 0 whenever the FSM leaves DRIVE, so it doubles as the
  // registered stimulus: {a,b,c,d} = vec_idx in DRIVE and 0000 elsewhere.
  assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
  assign bus.vec_idx     = vec_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tbl_q;
endmodule
